wr_dest_scoreboard: RTL and testbench

- Parametrised successor to the register-file write-destination mux.
- Selects the write-back register from instruction fields or fixed registers (SP, RA), then tracks it as a pending write with a per-operation latency.
- Emits one write-back pulse per destination when its latency expires, and exposes busy flags so control can stall on RAW/WAW hazards.
- Sits between the control FSM and the register-file write port of the multicycle CPU.

---
 rtl/wr_dest_scoreboard.sv | 146 ++++++++++++++
 tb/tb_wr_dest_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wr_dest_scoreboard.sv
// rtl/wr_dest_scoreboard.sv - write-destination select with pending-write scoreboard
// Picks the write-back register, tracks it for a given latency and strobes one write-back per destination.
module wr_dest_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int LAT_W  = 4,
  parameter int SP_REG = 29,
  parameter int RA_REG = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           seletor,
  input  logic [31:0]          instr,
  input  logic                 issue_valid,
  input  logic [LAT_W-1:0]     issue_lat,
  output logic                 issue_ready,
  output logic [ADDR_W-1:0]    dest_addr,
  input  logic                 flush,
  output logic                 wb_valid,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic [2**ADDR_W-1:0] busy_map,
  output logic                 rs_busy,
  output logic                 rt_busy,
  output logic [3:0]           pend_cnt
);
  localparam int NREG  = 2**ADDR_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] rs_f, rt_f, rd_f;
  logic              unused_instr;

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [LAT_W-1:0]  cnt_q  [DEPTH];
  logic [LAT_W-1:0]  cnt_d  [DEPTH];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              do_issue;

  assign rs_f = ADDR_W'(instr[25:21]);
  assign rt_f = ADDR_W'(instr[20:16]);
  assign rd_f = ADDR_W'(instr[15:11]);
  assign unused_instr = ^{instr[31:26], instr[10:0]};

  always_comb begin
    case (seletor)
      3'b000:  dest_addr = rt_f;
      3'b001:  dest_addr = ADDR_W'(SP_REG);
      3'b010:  dest_addr = ADDR_W'(RA_REG);
      3'b011:  dest_addr = rd_f;
      3'b100:  dest_addr = rs_f;
      default: dest_addr = '0;
    endcase
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + 4'(vld_q[i]);
  end

  // Register 0 is never tracked, so it is always accepted without taking a slot.
  assign issue_ready = (dest_addr == '0) || (free_found && !busy_q[dest_addr]);
  assign do_issue    = issue_valid && issue_ready && (dest_addr != '0) && !flush;

  always_comb begin
    vld_d  = vld_q;
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      cnt_d[i]  = (vld_q[i] && cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : cnt_q[i];
    end
    // The slot whose pulse is on the output now retires at this edge.
    if (gnt_q) begin
      vld_d[gnt_idx_q]          = 1'b0;
      busy_d[addr_q[gnt_idx_q]] = 1'b0;
    end
    if (do_issue) begin
      vld_d[free_idx]   = 1'b1;
      addr_d[free_idx]  = dest_addr;
      cnt_d[free_idx]   = issue_lat;
      busy_d[dest_addr] = 1'b1;
    end
    gnt_d     = 1'b0;
    gnt_idx_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_d[i] && cnt_d[i] == '0) begin
        gnt_d     = 1'b1;
        gnt_idx_d = IDX_W'(i);
      end
    end
    wb_addr_d = gnt_d ? addr_d[gnt_idx_d] : wb_addr_q;
    if (flush) begin
      vld_d     = '0;
      busy_d    = '0;
      gnt_d     = 1'b0;
      wb_addr_d = wb_addr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      busy_q    <= '0;
      gnt_q     <= 1'b0;
      gnt_idx_q <= '0;
      wb_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      wb_addr_q <= wb_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign wb_valid = gnt_q;
  assign wb_addr  = wb_addr_q;
  assign busy_map = busy_q;
  assign rs_busy  = busy_q[rs_f];
  assign rt_busy  = busy_q[rt_f];
endmodule

// File: tb/tb_wr_dest_scoreboard.sv
// tb/tb_wr_dest_scoreboard.sv - randomized and directed bench for wr_dest_scoreboard
// Reference keeps pending writes as entries with an absolute eligible cycle.
module tb_wr_dest_scoreboard;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  seletor = '0;
  logic [31:0] instr = '0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_lat = '0;
  logic        issue_ready;
  logic [4:0]  dest_addr;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] busy_map;
  logic        rs_busy, rt_busy;
  logic [3:0]  pend_cnt;

  wr_dest_scoreboard dut (
    .clk(clk), .reset(reset), .seletor(seletor), .instr(instr),
    .issue_valid(issue_valid), .issue_lat(issue_lat), .issue_ready(issue_ready),
    .dest_addr(dest_addr), .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy_map(busy_map), .rs_busy(rs_busy), .rt_busy(rt_busy), .pend_cnt(pend_cnt)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int now = 0;
  bit m_vld [DEPTH];
  int m_addr [DEPTH];
  int m_due [DEPTH];
  int m_wb_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_dest(input logic [2:0] s, input logic [31:0] w);
    case (s)
      3'd0: return w[20:16];
      3'd1: return 5'd29;
      3'd2: return 5'd31;
      3'd3: return w[15:11];
      3'd4: return w[25:21];
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int rs, input int rt, input int rd);
    return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  // Called in the low phase of a cycle: check that cycle, drive inputs, model the edge.
  task automatic cycle(input logic [2:0] sel, input logic [31:0] ins, input logic iv,
                       input logic [3:0] lat, input logic fl);
    bit wfound, ffound, er;
    int widx, fidx, cnt;
    logic [31:0] bm;
    logic [4:0] d;
    wfound = 0; widx = 0; ffound = 0; fidx = 0; cnt = 0; bm = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!wfound && m_vld[i] && m_due[i] <= now) begin wfound = 1; widx = i; end
    if (wfound) m_wb_addr = m_addr[widx];
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i]) begin bm[m_addr[i]] = 1'b1; cnt++; end
    chk("wb_valid", wb_valid, wfound);
    chk("wb_addr", wb_addr, m_wb_addr);
    chk("busy_map", busy_map, bm);
    chk("pend_cnt", pend_cnt, cnt);
    seletor = sel; instr = ins; issue_valid = iv; issue_lat = lat; flush = fl;
    #1;
    d = m_dest(sel, ins);
    for (int i = 0; i < DEPTH; i++)
      if (!ffound && !m_vld[i]) begin ffound = 1; fidx = i; end
    er = (d == 0) || (ffound && !bm[d]);
    chk("dest_addr", dest_addr, d);
    chk("issue_ready", issue_ready, er);
    chk("rs_busy", rs_busy, bm[ins[25:21]]);
    chk("rt_busy", rt_busy, bm[ins[20:16]]);
    if (fl) m_clear();
    else begin
      if (wfound) m_vld[widx] = 1'b0;
      if (iv && er && d != 0) begin
        m_vld[fidx] = 1'b1; m_addr[fidx] = d; m_due[fidx] = now + 1 + int'(lat);
      end
    end
    @(posedge clk); now++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(3'd0, 32'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic peek(input logic [2:0] sel, input logic [31:0] ins, output logic rdy);
    seletor = sel; instr = ins; #1; rdy = issue_ready;
  endtask

  task automatic do_reset();
    reset = 1'b0; #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_busy_map", busy_map, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    m_clear(); m_wb_addr = 0;
    @(posedge clk); now++;
    @(negedge clk); reset = 1'b1;
  endtask

  logic rdy;
  logic [31:0] mux_w;
  logic [2:0] mux_sel [6];
  int mux_exp [6];

  initial begin
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_wb_addr", wb_addr, 0);
    chk("reset_busy_map", busy_map, 0);
    chk("reset_pend_cnt", pend_cnt, 0);
    reset = 1'b1;

    mux_w = 32'h012A5820;
    mux_sel = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    mux_exp = '{10, 29, 31, 11, 9, 0};
    for (int i = 0; i < 6; i++) begin
      seletor = mux_sel[i]; instr = mux_w; #1;
      chk("mux_dest", dest_addr, mux_exp[i]);
    end
    @(negedge clk);

    cycle(3'b011, mux_w, 1'b1, 4'd3, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      chk("lat3_busy11", busy_map[11], k <= 4);
      chk("lat3_wb_valid", wb_valid, k == 4);
      if (k == 4) chk("lat3_wb_addr", wb_addr, 11);
      idle(1);
    end

    cycle(3'b001, 32'd0, 1'b1, 4'd2, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      peek(3'b001, 32'd0, rdy);
      chk("waw_ready", rdy, k == 4);
      idle(1);
    end

    idle(3);
    for (int r = 1; r <= 4; r++) cycle(3'b011, mk(0, 0, r), 1'b1, 4'd9, 1'b0);
    chk("full_pend", pend_cnt, 4);
    peek(3'b011, mk(0, 0, 5), rdy);
    chk("full_ready_r5", rdy, 0);
    peek(3'b110, mk(0, 0, 5), rdy);
    chk("full_ready_zero", rdy, 1);
    cycle(3'b110, mk(0, 0, 5), 1'b1, 4'd0, 1'b0);
    chk("zero_pend", pend_cnt, 4);
    chk("zero_no_wb", wb_valid, 0);
    idle(16);

    cycle(3'b011, mk(0, 0, 1), 1'b1, 4'd2, 1'b0);
    cycle(3'b011, mk(0, 0, 2), 1'b1, 4'd1, 1'b0);
    idle(1);
    chk("coll_wb0", wb_valid, 1);
    chk("coll_addr0", wb_addr, 1);
    idle(1);
    chk("coll_wb1", wb_valid, 1);
    chk("coll_addr1", wb_addr, 2);
    idle(1);
    chk("coll_wb2", wb_valid, 0);
    idle(3);

    cycle(3'b011, mk(0, 0, 8), 1'b1, 4'd5, 1'b0);
    idle(1);
    chk("flush_busy_before", busy_map, 32'h100);
    cycle(3'b000, 32'd0, 1'b0, 4'd0, 1'b1);
    chk("flush_busy_after", busy_map, 0);
    idle(8);

    cycle(3'b011, mk(0, 0, 8), 1'b1, 4'd5, 1'b0);
    idle(2);
    do_reset();
    idle(8);

    for (int k = 0; k < 4000; k++) begin
      if (k % 997 == 500) do_reset();
      cycle(3'($urandom_range(0, 7)),
            mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 6)),
            1'($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
